inst_fetch: RTL and testbench

Instruction fetch stage for the register+ALU CPU.
- Holds the program in an internal synchronous-read instruction memory and keeps a program counter.
- Presents one 32-bit instruction per cycle to the downstream execute stage (register file + ALU) over a valid/ready handshake.
- Supports program loading, PC redirect (jump) and optional halt detection.

---
 rtl/cpu_pkg.sv | 9 +
 rtl/inst_fetch_if.sv | 32 +++
 rtl/inst_mem.sv | 36 +++
 rtl/inst_fetch.sv | 90 +++++++++
 tb/tb_inst_fetch.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants used by the fetch stage and its memory.
// INST_W    : instruction word width
// NOP_INST  : writeen=0 encoding, a no-op for the execute stage
// HALT_INST : stops fetch when accepted (only if FETCH_HALT_EN is defined)
package cpu_pkg;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST  = 32'h0000_0007;
  localparam logic [INST_W-1:0] HALT_INST = 32'hFFFF_FFFF;
endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: program load, control (run/redirect) and the
// valid/ready instruction stream to execute.
// master : driver side (loader / control / execute stage)
// slave  : inst_fetch side
interface inst_fetch_if #(
  parameter int MEM_DEPTH = 256,
  parameter int PC_W      = $clog2(MEM_DEPTH)
);
  import cpu_pkg::*;

  logic              load_en;
  logic [PC_W-1:0]   load_addr;
  logic [INST_W-1:0] load_data;
  logic              run;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic [INST_W-1:0] inst;
  logic              inst_valid;
  logic              inst_ready;
  logic [PC_W-1:0]   pc_out;
  logic              halted;

  modport master (
    output load_en, load_addr, load_data, run, redirect_valid, redirect_pc, inst_ready,
    input  inst, inst_valid, pc_out, halted
  );

  modport slave (
    input  load_en, load_addr, load_data, run, redirect_valid, redirect_pc, inst_ready,
    output inst, inst_valid, pc_out, halted
  );
endinterface

// File: rtl/inst_mem.sv
// Instruction memory: MEM_DEPTH x INST_W, one synchronous write port and
// one synchronous read port (1-cycle latency). A read of an address that
// is written in the same cycle returns the old word. The array itself is
// not reset; only the read register is.
// Ports: clk, rst_n (sync, active-low), i_we/i_waddr/i_wdata write port,
//        i_re/i_raddr read request, o_rdata registered read data.
module inst_mem
  import cpu_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int PC_W      = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [PC_W-1:0]   i_waddr,
  input  logic [INST_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [PC_W-1:0]   i_raddr,
  output logic [INST_W-1:0] o_rdata
);
  logic [INST_W-1:0] r_mem [MEM_DEPTH];
  logic [INST_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Separate process from the write; NBA semantics give read-old-data.
  always_ff @(posedge clk) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, control and output register in front of an
// internal instruction memory. Presents one instruction per cycle over a
// valid/ready handshake; supports program load and PC redirect.
// Ports: clk, rst_n (sync, active-low), bus (inst_fetch_if.slave).
// Optional feature macro: FETCH_HALT_EN -- accepting HALT_INST stops fetch
// until a redirect or reset; without it halted is tied to 0.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int PC_W      = $clog2(MEM_DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  inst_fetch_if.slave  bus
);
  logic [PC_W-1:0]   r_fetch_pc;
  logic [PC_W-1:0]   r_pc_out;
  logic              r_inst_valid;
  logic [INST_W-1:0] w_rdata;
  logic [PC_W-1:0]   w_raddr;
  logic              w_stall, w_issue, w_we, w_re;
  logic              w_halted, w_halt_acc;

  assign w_stall = r_inst_valid && !bus.inst_ready;

`ifdef FETCH_HALT_EN
  logic r_halted;
  logic w_accept;

  assign w_accept   = r_inst_valid && bus.inst_ready;
  // Also blocks issue in the accept cycle itself so nothing past HALT
  // is ever presented.
  assign w_halt_acc = w_accept && (w_rdata == HALT_INST);
  assign w_halted   = r_halted;

  always_ff @(posedge clk) begin
    if (!rst_n)                  r_halted <= 1'b0;
    else if (bus.redirect_valid) r_halted <= 1'b0;
    else if (w_halt_acc)         r_halted <= 1'b1;
  end
`else
  assign w_halt_acc = 1'b0;
  assign w_halted   = 1'b0;
`endif

  assign w_issue = bus.run && !w_halted && !w_halt_acc && !bus.load_en &&
                   !bus.redirect_valid && !w_stall;

  // Re-reading pc_out while stalled keeps inst stable (and picks up a
  // load to that same word one cycle later).
  assign w_raddr = w_stall ? r_pc_out : r_fetch_pc;
  assign w_re    = w_issue || w_stall;
  assign w_we    = bus.load_en && rst_n;

  inst_mem #(.MEM_DEPTH(MEM_DEPTH), .PC_W(PC_W)) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (bus.load_addr),
    .i_wdata (bus.load_data),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc   <= '0;
      r_pc_out     <= '0;
      r_inst_valid <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_fetch_pc   <= bus.redirect_pc;
      r_inst_valid <= 1'b0;
    end else if (bus.load_en) begin
      if (!w_stall) r_inst_valid <= 1'b0;
    end else if (w_issue) begin
      r_pc_out     <= r_fetch_pc;
      r_inst_valid <= 1'b1;
      r_fetch_pc   <= r_fetch_pc + PC_W'(1);  // wraps at MEM_DEPTH
    end else if (!w_stall) begin
      r_inst_valid <= 1'b0;
    end
  end

  assign bus.inst       = w_rdata;
  assign bus.pc_out     = r_pc_out;
  assign bus.inst_valid = r_inst_valid;
  assign bus.halted     = w_halted;
endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
  import cpu_pkg::*;
  localparam int MEM_DEPTH = 256;
  localparam int PC_W      = 8;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     inst;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  inst_fetch_if #(.MEM_DEPTH(MEM_DEPTH)) bus ();
  inst_fetch #(.MEM_DEPTH(MEM_DEPTH)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  logic [31:0] shadow [MEM_DEPTH];
  exp_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic do_load(input logic [PC_W-1:0] a, input logic [31:0] d);
    bus.load_en = 1'b1; bus.load_addr = a; bus.load_data = d; shadow[a] = d;
    @(negedge clk);
    bus.load_en = 1'b0;
  endtask

  task automatic do_redirect(input logic [PC_W-1:0] a);
    bus.redirect_valid = 1'b1; bus.redirect_pc = a;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [PC_W-1:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      logic [PC_W-1:0] p;
      p = a + PC_W'(i);
      exp_q.push_back('{pc: p, inst: shadow[p]});
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.load_en = 0; bus.load_addr = 0; bus.load_data = 0; bus.run = 0;
    bus.redirect_valid = 0; bus.redirect_pc = 0; bus.inst_ready = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({bus.inst_valid, bus.pc_out, bus.inst, bus.halted} !== {1'b0, 8'd0, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: valid=%0b pc=%0d inst=%h halted=%0b, want 0/0/0/0",
               bus.inst_valid, bus.pc_out, bus.inst, bus.halted);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_fetch();
    exp_t e;
    for (int i = 0; i < 16; i++)
      do_load(PC_W'(i), (i < 4) ? 32'h10 + i : 32'hA000_0000 + i);
    do_load(8'd255, 32'h0000_00FF);
    push_exp(0, 4);
    bus.run = 1; bus.inst_ready = 1;
    n_chk++;
    if (bus.inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL load_fetch_prevalid: valid=%0b want 0", bus.inst_valid);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_chk++;
      if (!(bus.inst_valid && bus.inst_ready)) begin
        n_fail++; $display("FAIL load_fetch_bubble: cycle %0d valid=%0b want 1", c, bus.inst_valid);
      end else begin
        e = exp_q.pop_front();
        if ({bus.pc_out, bus.inst} !== e) begin
          n_fail++; $display("FAIL load_fetch: pc=%0d inst=%h want pc=%0d inst=%h", bus.pc_out, bus.inst, e.pc, e.inst);
        end
      end
    end
    bus.run = 0;
    exp_q.delete();
    @(negedge clk);
    n_chk++;
    if (bus.inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL load_fetch_stop: valid=%0b want 0", bus.inst_valid);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    bus.run = 1; bus.inst_ready = 1;
    do_redirect(0);
    push_exp(0, 4);
    @(negedge clk);                    // pc0 presented
    if (bus.inst_valid && bus.inst_ready) begin
      e = exp_q.pop_front(); n_chk++;
      if ({bus.pc_out, bus.inst} !== e) begin
        n_fail++; $display("FAIL bp_first: pc=%0d inst=%h want pc=%0d inst=%h", bus.pc_out, bus.inst, e.pc, e.inst);
      end
    end
    @(negedge clk);                    // pc1 presented, stall it
    bus.inst_ready = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_chk++;
      if ({bus.inst_valid, bus.pc_out, bus.inst} !== {1'b1, 8'd1, 32'h11}) begin
        n_fail++; $display("FAIL bp_hold%0d: valid=%0b pc=%0d inst=%h want 1/1/00000011", k, bus.inst_valid, bus.pc_out, bus.inst);
      end
      if (k == 0) begin
        bus.load_en = 1; bus.load_addr = 8'd5; bus.load_data = 32'h5555_0005; shadow[5] = 32'h5555_0005;
      end else bus.load_en = 0;
    end
    bus.inst_ready = 1;
    for (int c = 0; c < 16 && exp_q.size() > 0; c++) begin
      if (bus.inst_valid && bus.inst_ready) begin
        e = exp_q.pop_front(); n_chk++;
        if ({bus.pc_out, bus.inst} !== e) begin
          n_fail++; $display("FAIL bp_stream: pc=%0d inst=%h want pc=%0d inst=%h", bus.pc_out, bus.inst, e.pc, e.inst);
        end
      end
      if (exp_q.size() > 0) @(negedge clk);
    end
    bus.run = 0;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL bp_timeout: %0d left want 0", exp_q.size()); exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_redirect();
    exp_t e;
    bus.run = 1; bus.inst_ready = 1;
    do_redirect(0);
    push_exp(0, 2);
    for (int c = 0; c < 16 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (bus.inst_valid && bus.inst_ready) begin
        e = exp_q.pop_front(); n_chk++;
        if ({bus.pc_out, bus.inst} !== e) begin
          n_fail++; $display("FAIL redir_pre: pc=%0d inst=%h want pc=%0d inst=%h", bus.pc_out, bus.inst, e.pc, e.inst);
        end
      end
    end
    @(negedge clk);
    bus.inst_ready = 0;
    @(negedge clk);
    n_chk++;
    if ({bus.inst_valid, bus.pc_out} !== {1'b1, 8'd2}) begin
      n_fail++; $display("FAIL redir_stall: valid=%0b pc=%0d want 1/2", bus.inst_valid, bus.pc_out);
    end
    do_redirect(8'd8);
    bus.inst_ready = 1;
    n_chk++;
    if (bus.inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL redir_flush: valid=%0b want 0", bus.inst_valid);
    end
    push_exp(8'd8, 2);
    @(negedge clk);
    n_chk++;
    if ({bus.inst_valid, bus.pc_out} !== {1'b1, 8'd8}) begin
      n_fail++; $display("FAIL redir_first: valid=%0b pc=%0d want 1/8", bus.inst_valid, bus.pc_out);
    end
    for (int c = 0; c < 16 && exp_q.size() > 0; c++) begin
      if (bus.inst_valid && bus.inst_ready) begin
        e = exp_q.pop_front(); n_chk++;
        if ({bus.pc_out, bus.inst} !== e) begin
          n_fail++; $display("FAIL redir_stream: pc=%0d inst=%h want pc=%0d inst=%h", bus.pc_out, bus.inst, e.pc, e.inst);
        end
      end
      if (exp_q.size() > 0) @(negedge clk);
    end
    bus.run = 0;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL redir_timeout: %0d left want 0", exp_q.size()); exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    exp_t e;
    bus.run = 1; bus.inst_ready = 1;
    do_redirect(8'd255);
    push_exp(8'd255, 3);
    for (int c = 0; c < 16 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (bus.inst_valid && bus.inst_ready) begin
        e = exp_q.pop_front(); n_chk++;
        if ({bus.pc_out, bus.inst} !== e) begin
          n_fail++; $display("FAIL wrap: pc=%0d inst=%h want pc=%0d inst=%h", bus.pc_out, bus.inst, e.pc, e.inst);
        end
      end
    end
    bus.run = 0;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL wrap_timeout: %0d left want 0", exp_q.size()); exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_halt();
    exp_t e;
    do_load(8'd2, HALT_INST);
    bus.run = 1; bus.inst_ready = 1;
    do_redirect(0);
`ifdef FETCH_HALT_EN
    push_exp(0, 3);
`else
    push_exp(0, 4);
`endif
    for (int c = 0; c < 16 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (bus.inst_valid && bus.inst_ready) begin
        e = exp_q.pop_front(); n_chk++;
        if ({bus.pc_out, bus.inst} !== e) begin
          n_fail++; $display("FAIL halt_stream: pc=%0d inst=%h want pc=%0d inst=%h", bus.pc_out, bus.inst, e.pc, e.inst);
        end
      end
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL halt_timeout: %0d left want 0", exp_q.size()); exp_q.delete();
    end
`ifdef FETCH_HALT_EN
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_chk++;
      if ({bus.halted, bus.inst_valid} !== 2'b10) begin
        n_fail++; $display("FAIL halt_stopped%0d: halted=%0b valid=%0b want 1/0", k, bus.halted, bus.inst_valid);
      end
    end
    do_redirect(0);
    n_chk++;
    if ({bus.halted, bus.inst_valid} !== 2'b00) begin
      n_fail++; $display("FAIL halt_clear: halted=%0b valid=%0b want 0/0", bus.halted, bus.inst_valid);
    end
    @(negedge clk);
    n_chk++;
    if ({bus.inst_valid, bus.pc_out, bus.inst} !== {1'b1, 8'd0, 32'h10}) begin
      n_fail++; $display("FAIL halt_resume: valid=%0b pc=%0d inst=%h want 1/0/00000010", bus.inst_valid, bus.pc_out, bus.inst);
    end
`else
    n_chk++;
    if (bus.halted !== 1'b0) begin
      n_fail++; $display("FAIL halt_tied: halted=%0b want 0", bus.halted);
    end
`endif
    bus.run = 0;
    @(negedge clk);
    do_load(8'd2, 32'h12);
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    bus.run = 1; bus.inst_ready = 1;
    do_redirect(0);
    push_exp(0, 2);
    for (int c = 0; c < 16 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (bus.inst_valid && bus.inst_ready) begin
        e = exp_q.pop_front(); n_chk++;
        if ({bus.pc_out, bus.inst} !== e) begin
          n_fail++; $display("FAIL rst_pre: pc=%0d inst=%h want pc=%0d inst=%h", bus.pc_out, bus.inst, e.pc, e.inst);
        end
      end
    end
    // Reset with a simultaneous load to word 0: the load must be dropped.
    rst_n = 0; bus.load_en = 1; bus.load_addr = 0; bus.load_data = 32'hDEAD_BEEF;
    @(negedge clk);
    n_chk++;
    if ({bus.inst_valid, bus.pc_out, bus.inst, bus.halted} !== {1'b0, 8'd0, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL rst_mid: valid=%0b pc=%0d inst=%h halted=%0b want 0/0/0/0",
                         bus.inst_valid, bus.pc_out, bus.inst, bus.halted);
    end
    rst_n = 1; bus.load_en = 0;
    push_exp(0, 1);
    @(negedge clk);
    n_chk++;
    if (!bus.inst_valid) begin
      n_fail++; $display("FAIL rst_resume: valid=%0b want 1", bus.inst_valid);
    end else begin
      e = exp_q.pop_front();
      if ({bus.pc_out, bus.inst} !== e) begin
        n_fail++; $display("FAIL rst_resume: pc=%0d inst=%h want pc=%0d inst=%h", bus.pc_out, bus.inst, e.pc, e.inst);
      end
    end
    exp_q.delete();
    bus.run = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_load_fetch();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end
endmodule
